// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, FSM state encoding and the sample-pair record.
// Used by both the transmitter and the receiver side of the link.
package i2s_pkg;

   localparam int unsigned SLOT_BITS   = 24;
   localparam int unsigned FRAME_SLOTS = 48;
   localparam int unsigned FRAME_BITS  = 2 * SLOT_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      XMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [SLOT_BITS-1:0] lft;
      logic [SLOT_BITS-1:0] rght;
   } frame_t;

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock generator: divides clk by 2*SCLK_DIV and flags the clk cycle
// in which sclk is about to rise or fall. Held at 0 (divider cleared) while run is low.
module i2s_sclk_gen #(
   parameter int unsigned SCLK_DIV = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sclk,
   output logic sclk_fall_evt,
   output logic sclk_rise_evt
);

   localparam logic [7:0] TERM = 8'(SCLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       tick;

   assign tick = run && (cnt_q == TERM);

   // NOTE: every next-state value is given a default before any branch, so no latch can be inferred.
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!run) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         cnt_d  = cnt_q + 8'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk          = sclk_q;
   assign sclk_fall_evt = tick & sclk_q;
   assign sclk_rise_evt = tick & ~sclk_q;

endmodule

// File: rtl/i2s_ser_tx.sv
// I2S transmitter: a holding register fed by ld/rdy and a 48-bit shifter that
// serializes left then right MSB-first, data and ws changing on sclk fall.
module i2s_ser_tx
   import i2s_pkg::*;
#(
   parameter int unsigned SCLK_DIV = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [SLOT_BITS-1:0] lft_chnnl,
   input  logic [SLOT_BITS-1:0] rght_chnnl,
   input  logic                 ld,
   output logic                 rdy,
   output logic                 undrn,
   output logic                 I2S_sclk,
   output logic                 I2S_ws,
   output logic                 I2S_data
);

   localparam logic [5:0] LAST_SLOT  = 6'(FRAME_SLOTS - 1);
   localparam logic [5:0] WS_HI_SLOT = 6'(SLOT_BITS - 2);
   localparam logic [5:0] WS_LO_SLOT = 6'(FRAME_SLOTS - 2);

   state_e                state_q, state_d;
   logic [5:0]            slot_q, slot_d;
   frame_t                hold_q, hold_d;
   logic                  full_q, full_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  ws_q, ws_d;
   logic                  data_q, data_d;
   logic                  undrn_q, undrn_d;

   logic run, sclk_fall, sclk_rise_unused;
   logic frame_start, accept;

   assign run = (state_q != IDLE);

   i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .sclk          (I2S_sclk),
      .sclk_fall_evt (sclk_fall),
      .sclk_rise_evt (sclk_rise_unused)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      hold_d      = hold_q;
      full_d      = full_q;
      shift_d     = shift_q;
      ws_d        = ws_q;
      data_d      = data_q;
      undrn_d     = 1'b0;
      frame_start = 1'b0;
      accept      = ld && !full_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = LEAD;
               ws_d    = 1'b0;
               data_d  = 1'b0;
            end
         end
         LEAD: begin
            if (sclk_fall) frame_start = 1'b1;
         end
         XMIT: begin
            if (sclk_fall) begin
               if (slot_q == LAST_SLOT) begin
                  if (en) begin
                     frame_start = 1'b1;
                  end else begin
                     state_d = IDLE;
                     slot_d  = '0;
                     ws_d    = 1'b1;
                     data_d  = 1'b0;
                  end
               end else begin
                  slot_d  = slot_q + 6'd1;
                  data_d  = shift_q[FRAME_BITS-1];
                  shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                  // ws leads each channel's MSB by one slot
                  if (slot_q == WS_HI_SLOT)      ws_d = 1'b1;
                  else if (slot_q == WS_LO_SLOT) ws_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An empty holding register at a frame start sends a silent frame.
      if (frame_start) begin
         state_d = XMIT;
         slot_d  = '0;
         full_d  = 1'b0;
         undrn_d = !full_q;
         data_d  = full_q & hold_q.lft[SLOT_BITS-1];
         shift_d = full_q ? {hold_q.lft[SLOT_BITS-2:0], hold_q.rght, 1'b0} : '0;
      end

      if (accept) begin
         hold_d = '{lft: lft_chnnl, rght: rght_chnnl};
         full_d = 1'b1;
      end
   end

   // NOTE: the sample registers are reset as well, so a reset mid-frame never replays stale audio.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         hold_q  <= '0;
         full_q  <= 1'b0;
         shift_q <= '0;
         ws_q    <= 1'b1;
         data_q  <= 1'b0;
         undrn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         shift_q <= shift_d;
         ws_q    <= ws_d;
         data_q  <= data_d;
         undrn_q <= undrn_d;
      end
   end

   assign rdy      = ~full_q;
   assign undrn    = undrn_q;
   assign I2S_ws   = ws_q;
   assign I2S_data = data_q;

endmodule

// File: doc/i2s_ser_tx.md
# i2s_ser_tx

I2S transmitter: accepts 24-bit left/right sample pairs over a load/ready handshake and serializes them MSB-first onto I2S_sclk/I2S_ws/I2S_data, generating the bit clock and word select itself. It is the send-side counterpart of the I2S receiver: 24-bit slots, ws leading the MSB by one slot, data changing on sclk fall so the far end samples on sclk rise. It sits between the audio datapath (sample source) and the board I2S pins.

## Interface
- SCLK_DIV, 8, I2S_sclk half-period in clk cycles; legal range 4..255.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  transmit enable; sampled at frame boundaries.
- lft_chnnl  in  24  left sample, two's complement.
- rght_chnnl  in  24  right sample, two's complement.
- ld  in  1  one-cycle load strobe; captures lft_chnnl/rght_chnnl when rdy=1.
- rdy  out  1  holding register empty, ld will be accepted.
- undrn  out  1  one-cycle pulse: frame started with holding register empty.
- I2S_sclk  out  1  bit clock, 50% duty.
- I2S_ws  out  1  word select: 0 = left, 1 = right.
- I2S_data  out  1  serial data.

## Operation
- Reset values: I2S_sclk=0, I2S_ws=1, I2S_data=0, rdy=1, undrn=0; state IDLE, counters 0, holding empty, shifter 0.
- Two 48-bit stages: holding register (written by ld) and shifter (drives I2S_data).
- ld while rdy=1: capture {lft_chnnl,rght_chnnl}, rdy goes 0 next cycle. ld while rdy=0: ignored, data dropped, no flag.
- Frame = 48 slots (one sclk period each), index 0..47: slots 0..23 left MSB..LSB, 24..47 right MSB..LSB.
- I2S_ws changes at the sclk fall beginning slot 23 (to 1) and slot 47 (to 0), i.e. one slot ahead of the channel MSB.
- States: IDLE, LEAD, XMIT.
  - IDLE: sclk held 0, ws=1, data=0. en=1 -> LEAD.
  - LEAD: one sclk period with ws=0, data=0 (stands in for slot 47). Its closing sclk fall -> XMIT, slot 0.
  - XMIT: at each sclk fall, shift out the next bit and advance slot index. At the fall beginning slot 0 (wrap from 47, or from LEAD): if en=0 (XMIT only) -> IDLE; else transfer holding -> shifter, set holding empty.
- Transfer with holding empty: shifter loaded with 0, undrn pulses that cycle; the frame transmits silence.
- ld coincident with a transfer: if holding was empty, ld is captured into holding (for the next frame) and that frame's undrn still pulses; if full, ld is ignored (rdy was 0).
- en deassert mid-frame: current frame completes through slot 47; IDLE entered at the next frame boundary, holding contents retained.
- Loads accepted in IDLE; the first frame after en carries them.

## Timing
- Divider counts 0..SCLK_DIV-1 and toggles sclk at terminal count; all outputs registered, changing only on the clk edge where sclk toggles (ws/data only on the 1->0 toggle).
- en high in IDLE -> ws=0 one clk later; divider restarts; first sclk rise SCLK_DIV clk later; left MSB on I2S_data 2*SCLK_DIV+1 clk after en sampled.
- Frame period 96*SCLK_DIV clk.
- rdy rises the clk after the slot-0 transfer; undrn coincides with the transfer cycle.
- rst_n low mid-frame: all outputs to reset values immediately (async); the far-end receiver sees ws rise and resynchronizes.

## Structure
- Package i2s_pkg: state enum (IDLE, LEAD, XMIT), SLOT_BITS=24, FRAME_SLOTS=48, shared with the receiver.
- Sub-module i2s_sclk_gen: divider + sclk register, outputs sclk, sclk_fall_evt, sclk_rise_evt; reset restarts divider.
- Top: FSM, 6-bit slot counter, holding/shifter, handshake.

## Test plan
- ld {24'hA5A5A5, 24'h5A5A5A}, en=1, SCLK_DIV=8 -> ws=0 after 1 clk, first MSB at clk 17; receiver loopback reports lft=A5A5A5, rght=5A5A5A, vld once.
- en=1, no ld -> undrn pulse at slot 0, 48 zero bits, rdy stays 1; ld mid-frame -> next frame carries data, no undrn.
- Two ld strobes back-to-back with no frame between -> second ignored, transmitted pair = first.
- en dropped at slot 10 -> slots 11..47 complete, then sclk stays 0, ws=1, data=0; no further undrn.
- Samples 24'h800000/24'h7FFFFF continuous over 4 frames with ld each frame -> ws transitions exactly at slots 23/47, loopback exact, no undrn.
- rst_n pulsed at slot 30 -> outputs to reset values same cycle, rdy=1; re-enable -> clean LEAD then frame.
